// File: rtl/rs_dep_scheduler_pkg.sv
// rs_dep_scheduler_pkg: shared core types and sizing for the reservation-station scheduler
package rs_dep_scheduler_pkg;
    localparam int NUM_FUS    = 4;
    localparam int RS_ENTRIES = 4;
    typedef struct packed {
        logic [7:0] op;
        logic [7:0] tag;
    } disp_packet_t;
endpackage

// File: rtl/rs_dep_scheduler_prio_enc.sv
// rs_prio_enc: lowest-set-bit encoder giving one-hot, binary index (0 when none) and any
//   req    - request vector
//   onehot - lowest set bit of req isolated
//   idx    - index of that bit
//   any    - req has at least one bit set
module rs_prio_enc #(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    assign onehot = req & (~req + N'(1));
    assign any    = |req;
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
endmodule

// File: rtl/rs_dep_scheduler.sv
// rs_dep_scheduler: unified reservation station with dependency-matrix wakeup and per-FU issue select
//   clk, rst                       - clock, synchronous active-high reset
//   flush                          - discard all entries, suppress issue this cycle
//   disp_valid/pkt/fu, dependency_mask - dispatch request, payload, FU channel, producer entries
//   rs_entry_idx, rs_full, rs_count    - allocation slot, full flag, occupancy
//   fu_ready, issue_valid/pkt/idx      - per-channel issue handshake and selected entry
module rs_dep_scheduler
    import rs_dep_scheduler_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int NUM_FUS = rs_dep_scheduler_pkg::NUM_FUS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   disp_valid,
    input  disp_packet_t                           disp_pkt,
    input  logic [$clog2(NUM_FUS)-1:0]             disp_fu,
    input  logic [ENTRIES-1:0]                     dependency_mask,
    output logic [$clog2(ENTRIES)-1:0]             rs_entry_idx,
    output logic                                   rs_full,
    output logic [$clog2(ENTRIES+1)-1:0]           rs_count,
    input  logic [NUM_FUS-1:0]                     fu_ready,
    output logic [NUM_FUS-1:0]                     issue_valid,
    output disp_packet_t [NUM_FUS-1:0]             issue_pkt,
    output logic [NUM_FUS-1:0][$clog2(ENTRIES)-1:0] issue_idx
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int FUW  = $clog2(NUM_FUS);
    localparam int CNTW = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] valid, ready, fire_vec, alloc_oh, new_dep;
    logic [ENTRIES-1:0] dep [ENTRIES];
    logic [FUW-1:0]     fu  [ENTRIES];
    disp_packet_t       pkt [ENTRIES];
    logic [IDXW-1:0]    alloc_idx;
    logic               alloc_any, accept;
    logic [NUM_FUS-1:0][ENTRIES-1:0] ch_oh;
    logic [NUM_FUS-1:0] ch_any;
    logic [CNTW-1:0]    n_fire;

    always_comb begin
        ready = '0;
        for (int i = 0; i < ENTRIES; i++)
            ready[i] = valid[i] && dep[i] == '0;
    end

    rs_prio_enc #(.N(ENTRIES), .IW(IDXW)) u_alloc (
        .req(~valid), .onehot(alloc_oh), .idx(alloc_idx), .any(alloc_any)
    );

    assign rs_full      = !alloc_any;
    assign rs_entry_idx = alloc_idx;

    for (genvar f = 0; f < NUM_FUS; f++) begin : g_ch
        logic [ENTRIES-1:0] req;
        always_comb begin
            req = '0;
            for (int i = 0; i < ENTRIES; i++)
                req[i] = ready[i] && fu[i] == FUW'(f);
        end
        rs_prio_enc #(.N(ENTRIES), .IW(IDXW)) u_sel (
            .req(req), .onehot(ch_oh[f]), .idx(issue_idx[f]), .any(ch_any[f])
        );
        assign issue_pkt[f] = pkt[issue_idx[f]];
    end

    assign issue_valid = ch_any & {NUM_FUS{!flush}};

    always_comb begin
        fire_vec = '0;
        n_fire   = '0;
        for (int f = 0; f < NUM_FUS; f++)
            if (issue_valid[f] && fu_ready[f]) fire_vec = fire_vec | ch_oh[f];
        for (int i = 0; i < ENTRIES; i++)
            n_fire = n_fire + CNTW'(fire_vec[i]);
    end

    assign accept = disp_valid && alloc_any && !flush;
    // producers issuing this edge are already satisfied; the free slot itself is never valid
    assign new_dep = dependency_mask & valid & ~fire_vec & ~alloc_oh;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid    <= '0;
            rs_count <= '0;
            for (int i = 0; i < ENTRIES; i++) dep[i] <= '0;
        end else begin
            valid    <= (valid & ~fire_vec) | (accept ? alloc_oh : '0);
            rs_count <= rs_count + CNTW'(accept) - n_fire;
            for (int i = 0; i < ENTRIES; i++)
                dep[i] <= (accept && alloc_oh[i]) ? new_dep : dep[i] & ~fire_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fu[alloc_idx]  <= disp_fu;
            pkt[alloc_idx] <= disp_pkt;
        end
    end
endmodule

// File: tb/tb_rs_dep_scheduler.sv
// tb_rs_dep_scheduler: directed self-checking bench for rs_dep_scheduler
module tb_rs_dep_scheduler;
    import rs_dep_scheduler_pkg::*;

    logic clk = 0;
    logic rst, flush, disp_valid;
    disp_packet_t disp_pkt;
    logic [1:0] disp_fu;
    logic [15:0] dependency_mask;
    logic [3:0] rs_entry_idx;
    logic rs_full;
    logic [4:0] rs_count;
    logic [3:0] fu_ready, issue_valid;
    disp_packet_t [3:0] issue_pkt;
    logic [3:0][3:0] issue_idx;
    int checks = 0, errors = 0;

    rs_dep_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_pkt(disp_pkt),
        .disp_fu(disp_fu), .dependency_mask(dependency_mask), .rs_entry_idx(rs_entry_idx),
        .rs_full(rs_full), .rs_count(rs_count), .fu_ready(fu_ready), .issue_valid(issue_valid),
        .issue_pkt(issue_pkt), .issue_idx(issue_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic v, input logic [1:0] f, input logic [15:0] m, input logic [7:0] t);
        disp_valid      = v;
        disp_fu         = f;
        dependency_mask = m;
        disp_pkt        = '{op: 8'h0, tag: t};
    endtask

    task automatic do_reset;
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    initial begin
        flush = 0;
        fu_ready = 0;
        set_disp(0, 0, 0, 0);
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        check("rst_count", rs_count, 0);
        check("rst_full", rs_full, 0);
        check("rst_idx", rs_entry_idx, 0);
        check("rst_issue", issue_valid, 0);

        // fill: fu 3 only on entry 5, others i%3
        for (int i = 0; i < 16; i++) begin
            set_disp(1, (i == 5) ? 2'd3 : 2'(i % 3), 0, 8'(i));
            #1;
            check("fill_idx", rs_entry_idx, i);
            check("fill_full", rs_full, 0);
            tick();
        end
        set_disp(0, 0, 0, 0);
        #1;
        check("full_flag", rs_full, 1);
        check("full_count", rs_count, 16);
        check("full_issue", issue_valid, 4'b1111);
        check("full_ch3_idx", issue_idx[3], 5);
        check("full_ch3_tag", issue_pkt[3].tag, 5);
        check("full_ch2_idx", issue_idx[2], 2);
        set_disp(1, 0, 0, 8'hEE);
        #1;
        check("full_alloc0", rs_entry_idx, 0);
        tick();
        check("drop17_count", rs_count, 16);
        check("drop17_ch0_tag", issue_pkt[0].tag, 0);

        // fire entry 5 while full; dispatch dropped
        fu_ready = 4'b1000;
        set_disp(1, 0, 0, 8'hAA);
        #1;
        check("fire5_full", rs_full, 1);
        tick();
        fu_ready = 0;
        set_disp(0, 0, 0, 0);
        #1;
        check("fire5_count", rs_count, 15);
        check("fire5_idx", rs_entry_idx, 5);
        check("fire5_full_after", rs_full, 0);
        check("fire5_ch3", issue_valid, 4'b0111);
        set_disp(1, 3, 0, 8'h55);
        tick();
        set_disp(0, 0, 0, 0);
        #1;
        check("refill_count", rs_count, 16);
        check("refill_ch3", issue_valid, 4'b1111);
        check("refill_tag", issue_pkt[3].tag, 8'h55);
        check("refill_idx", issue_idx[3], 5);

        // reset mid-run with FUs ready: nothing issues, all cleared
        fu_ready = 4'b1111;
        rst = 1;
        tick();
        rst = 0;
        fu_ready = 0;
        #1;
        check("midrst_count", rs_count, 0);
        check("midrst_idx", rs_entry_idx, 0);
        check("midrst_issue", issue_valid, 0);

        // back-to-back wakeup
        set_disp(1, 0, 0, 8'h10);
        tick();
        set_disp(1, 1, 16'h0001, 8'h11);
        tick();
        set_disp(0, 0, 0, 0);
        #1;
        check("b2b_wait", issue_valid, 4'b0001);
        fu_ready = 4'b1111;
        #1;
        check("b2b_n", issue_valid, 4'b0001);
        tick();
        check("b2b_n1", issue_valid, 4'b0010);
        check("b2b_idx", issue_idx[1], 1);
        check("b2b_tag", issue_pkt[1].tag, 8'h11);
        check("b2b_count", rs_count, 1);
        tick();
        check("b2b_empty", issue_valid, 0);
        check("b2b_count0", rs_count, 0);
        fu_ready = 0;

        // dispatch depending on an entry that fires the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_disp(1, (i < 3) ? 2'd1 : 2'd2, 0, 8'(8'h20 + i));
            tick();
        end
        fu_ready = 4'b0100;
        set_disp(1, 0, 16'h0008, 8'h30);
        #1;
        check("samefire_alloc", rs_entry_idx, 4);
        tick();
        fu_ready = 0;
        set_disp(0, 0, 0, 0);
        #1;
        check("samefire_issue", issue_valid, 4'b0011);
        check("samefire_idx", issue_idx[0], 4);
        check("samefire_count", rs_count, 4);

        // four channels fire together, plus a dispatch in the same cycle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_disp(1, 2'(i % 4), 0, 8'(8'h40 + i));
            tick();
        end
        set_disp(1, 3, 0, 8'h50);
        fu_ready = 4'b1111;
        #1;
        check("quad_issue", issue_valid, 4'b1111);
        check("quad_idx2", issue_idx[2], 2);
        check("quad_alloc", rs_entry_idx, 5);
        tick();
        fu_ready = 0;
        set_disp(0, 0, 0, 0);
        #1;
        check("quad_count", rs_count, 2);
        check("quad_after", issue_valid, 4'b1001);
        check("quad_ch0_idx", issue_idx[0], 4);
        check("quad_ch3_tag", issue_pkt[3].tag, 8'h50);

        // flush overrides issue and dispatch
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_disp(1, 2'(i % 4), 0, 8'(i));
            tick();
        end
        check("pre_flush_count", rs_count, 7);
        fu_ready = 4'b1111;
        flush = 1;
        set_disp(1, 0, 0, 8'h77);
        #1;
        check("flush_issue", issue_valid, 0);
        tick();
        flush = 0;
        fu_ready = 0;
        set_disp(0, 0, 0, 0);
        #1;
        check("flush_count", rs_count, 0);
        check("flush_idx", rs_entry_idx, 0);
        check("flush_issue_after", issue_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
